// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants and state encoding for the binary-to-BCD converter
package bin2bcd_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Number of BCD digits produced (units, tens, hundreds)
    localparam int BCD_DIGITS = 3;

    // Code the downstream seven-segment decoder renders as all segments off
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Digit value shown on every position when the input saturates
    localparam logic [3:0] DIGIT_SAT = 4'd9;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // A digit of 5 or more would pass 9 after the next doubling, so pre-add 3
    always_comb begin
        digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter (optional BIN2BCD_LEADING_BLANK_EN)
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W   = 10,
    parameter int MAX_VAL = 999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [3:0]       U,
    output logic [3:0]       T,
    output logic [3:0]       H,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int               SCR_W    = 4 * BCD_DIGITS;
    localparam int               CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [31:0]      MAX_U    = MAX_VAL;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [3:0]         u_q, u_d;
    logic [3:0]         t_q, t_d;
    logic [3:0]         h_q, h_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [SCR_W-1:0]   adj;
    logic [3:0]         h_fin, t_fin, u_fin;

    // Add-3 correction applied to every scratch digit before each shift
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch_q[4*g +: 4]),
            .digit_out (adj[4*g +: 4])
        );
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            ovf_pend_q <= 1'b0;
            u_q        <= 4'd0;
            t_q        <= 4'd0;
            h_q        <= 4'd0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            ovf_pend_q <= ovf_pend_d;
            u_q        <= u_d;
            t_q        <= t_d;
            h_q        <= h_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: start only counts in IDLE; last shift step leads to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (count_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Final digits: saturate to 999 on overflow, otherwise optionally blank leading zeros
    always_comb begin
        h_fin = scratch_q[11:8];
        t_fin = scratch_q[7:4];
        u_fin = scratch_q[3:0];
        if (ovf_pend_q) begin
            h_fin = DIGIT_SAT;
            t_fin = DIGIT_SAT;
            u_fin = DIGIT_SAT;
        end else begin
`ifdef BIN2BCD_LEADING_BLANK_EN
            if (scratch_q[11:8] == 4'd0) begin
                h_fin = BCD_BLANK;
                if (scratch_q[7:4] == 4'd0) begin
                    t_fin = BCD_BLANK;
                end
            end
`else
            h_fin = scratch_q[11:8];
`endif
        end
    end

    // Datapath: load on accept, shift-add-3 per cycle, publish digits on DONE
    always_comb begin
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        ovf_pend_d = ovf_pend_q;
        u_d        = u_q;
        t_d        = t_q;
        h_d        = h_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d    = bin;
                    scratch_d  = '0;
                    count_d    = CNT_INIT;
                    ovf_pend_d = (32'(bin) > MAX_U);
                end
            end
            S_SHIFT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                count_d              = count_q - CNT_LAST;
            end
            S_DONE: begin
                u_d    = u_fin;
                t_d    = t_fin;
                h_d    = h_fin;
                ovf_d  = ovf_pend_q;
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Outputs: busy covers SHIFT and DONE, so it falls on the edge that raises done
    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        ovf  = ovf_q;
        U    = u_q;
        T    = t_q;
        H    = h_q;
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

`ifdef BIN2BCD_LEADING_BLANK_EN
    localparam logic [3:0] LZ = 4'hF;
`else
    localparam logic [3:0] LZ = 4'h0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic [9:0] bin;
    logic [3:0] U, T, H;
    logic       busy, done, ovf;

    int checks   = 0;
    int failures = 0;

    bin2bcd_seq #(.BIN_W(10), .MAX_VAL(999)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .U     (U),
        .T     (T),
        .H     (H),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] eh, input logic [3:0] et,
                             input logic [3:0] eu, input logic eovf);
        check({tag, ".H"}, int'(H), int'(eh));
        check({tag, ".T"}, int'(T), int'(et));
        check({tag, ".U"}, int'(U), int'(eu));
        check({tag, ".ovf"}, int'(ovf), int'(eovf));
    endtask

    // Issue start at the current time (just after an edge); return edges until done
    task automatic do_conv(input logic [9:0] v, output int lat);
        start = 1'b1;
        bin   = v;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 10'($urandom);
        lat   = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int lat;
    int npulse;
    int last_pulse;
    int pulses[$];

    initial begin
        reset = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_out("rst", 4'd0, 4'd0, 4'd0, 1'b0);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // zero input, latency check
        do_conv(10'd0, lat);
        check("zero.lat", lat, 11);
        check("zero.busy", int'(busy), 0);
        check_out("zero", LZ, LZ, 4'd0, 1'b0);
        @(posedge clk); #1;
        check("zero.done_pulse", int'(done), 0);

        do_conv(10'd255, lat);
        check("255.lat", lat, 11);
        check_out("255", 4'd2, 4'd5, 4'd5, 1'b0);

        do_conv(10'd7, lat);
        check_out("7", LZ, LZ, 4'd7, 1'b0);

        // back-to-back, each start issued in the done cycle
        do_conv(10'd999, lat);
        check("999.lat", lat, 11);
        check_out("999", 4'd9, 4'd9, 4'd9, 1'b0);
        do_conv(10'd1000, lat);
        check("1000.lat", lat, 11);
        check_out("1000", 4'd9, 4'd9, 4'd9, 1'b1);
        do_conv(10'd100, lat);
        check("100.lat", lat, 11);
        check_out("100", 4'd1, 4'd0, 4'd0, 1'b0);
        @(posedge clk); #1;

        // start while busy is ignored
        start = 1'b1;
        bin   = 10'd512;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("512.busy", int'(busy), 1);
        check_out("512.hold", 4'd1, 4'd0, 4'd0, 1'b0);
        start = 1'b1;
        bin   = 10'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 4;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("512.lat", lat, 11);
        check_out("512", 4'd5, 4'd1, 4'd2, 1'b0);
        npulse = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        check("512.extra_done", npulse, 0);
        check("512.busy_after", int'(busy), 0);
        check_out("512.after", 4'd5, 4'd1, 4'd2, 1'b0);

        // reset mid-conversion
        start = 1'b1;
        bin   = 10'd837;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_out("abort", 4'd0, 4'd0, 4'd0, 1'b0);
        check("abort.busy", int'(busy), 0);
        npulse = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        reset = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        check("abort.done", npulse, 0);
        check("abort.busy_after", int'(busy), 0);
        check_out("abort.after", 4'd0, 4'd0, 4'd0, 1'b0);

        do_conv(10'd42, lat);
        check("42.lat", lat, 11);
        check_out("42", LZ, 4'd4, 4'd2, 1'b0);

        // start held high: free-running conversions
        start = 1'b1;
        bin   = 10'd61;
        @(posedge clk); #1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses.push_back(c);
                check_out("61.pulse", LZ, 4'd6, 4'd1, 1'b0);
            end
            if (c == 29) begin
                check_out("61.mid", LZ, 4'd6, 4'd1, 1'b0);
                check("61.mid_busy", int'(busy), 1);
            end
        end
        start = 1'b0;
        check("61.npulse", pulses.size(), 3);
        last_pulse = 0;
        foreach (pulses[i]) begin
            check("61.pulse_cycle", pulses[i], 11 + 12 * i);
            last_pulse = pulses[i];
        end
        check("61.last", last_pulse, 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
